painterengine_gpu_memcpy_arbiter: RTL
=====================================

PAINTERENGINE_GPU_MEMCPY_ARBITER -- requirements
Module: painterengine_gpu_memcpy_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 32'd1048576, giving the maximum number of WAIT cycles per job; 0 disables the timeout.
REQ-002 i_wire_clock  in  1  clock; all logic SHALL be on its rising edge.
REQ-003 i_wire_resetn  in  1  reset; asynchronous, active-low.
REQ-004 i_wire_req  in  4  per-requester request level; bit k belongs to requester k.
REQ-005 i_wire_source_address  in  128  packed source addresses; requester k uses bits [32k+31:32k].
REQ-006 i_wire_dest_address  in  128  packed destination addresses, packed the same way.
REQ-007 i_wire_length  in  128  packed byte lengths, packed the same way.
REQ-008 o_wire_grant  out  4  one-hot bit for the job owner; high from LOAD through REPORT.
REQ-009 o_wire_done  out  4  one-cycle pulse to the owner when its job completes successfully.
REQ-010 o_wire_error  out  4  one-cycle pulse to the owner when its job fails.
REQ-011 o_wire_status  out  32  terminal engine state of the last job (6=DONE, 7/8/9=engine errors, 32'h0000000A=timeout).
REQ-012 o_wire_busy  out  1  high in any state other than IDLE.
REQ-013 o_wire_memcpy_resetn  out  1  reset to the copy engine; low holds the engine idle.
REQ-014 o_wire_memcpy_source_address, o_wire_memcpy_dest_address, o_wire_memcpy_length  out  32 each  latched parameters of the granted job.
REQ-015 i_wire_memcpy_state  in  32  copy-engine state word.

Function
REQ-016 The state machine SHALL have states IDLE, LOAD, RUN, WAIT and REPORT.
REQ-017 IDLE: o_wire_memcpy_resetn=0; if any request bit is high, select the winner by round-robin and go to LOAD.
REQ-018 Round-robin: search starts at last_grant+1 modulo 4; the first set bit wins; last_grant is updated on every grant.
REQ-019 LOAD: o_wire_grant is registered; the winner's three 32-bit parameters are latched onto the engine ports; o_wire_memcpy_resetn stays 0; next state is RUN.
REQ-020 Latched parameters SHALL stay stable until the next LOAD; requester input changes after LOAD are ignored.
REQ-021 RUN: o_wire_memcpy_resetn=1; the timeout counter is cleared; next state is WAIT.
REQ-022 WAIT: o_wire_memcpy_resetn=1; the counter increments each cycle.
REQ-023 WAIT exit on engine state 6: latch 6 into status, then go to REPORT.
REQ-024 WAIT exit on engine state 7, 8 or 9: latch that value into status, then go to REPORT.
REQ-025 WAIT exit on timeout, when TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1: latch 32'h0000000A into status, then go to REPORT.
REQ-026 An engine terminal state seen in the same cycle as the timeout SHALL take priority over the timeout.
REQ-027 REPORT: pulse o_wire_done[owner] if status=6, otherwise pulse o_wire_error[owner]; drive o_wire_memcpy_resetn=0; go to IDLE.
REQ-028 o_wire_grant SHALL clear when the block leaves REPORT.
REQ-029 Deasserting a request mid-job SHALL NOT abort the job; the report is still pulsed to that requester.
REQ-030 A requester still asserting req in the first IDLE cycle after REPORT is re-eligible, but round-robin places it last.
REQ-031 Minimum turnaround SHALL be 5 cycles from a request seen in IDLE to the next IDLE, plus the engine run time.
REQ-032 Engine states other than 6–9 (for example 0–5) SHALL be treated as in-progress.
REQ-033 The counter SHALL be 32 bits and SHALL saturate rather than wrap.

Reset
REQ-034 On reset, at any time including mid-job, the block SHALL enter IDLE.
REQ-035 On reset, all outputs SHALL be 0, including o_wire_memcpy_resetn, which holds the engine in reset.
REQ-036 On reset, last_grant SHALL be set to 3 so that requester 0 wins first.
REQ-037 On reset, status and the counter SHALL be set to 0.

Structure
REQ-038 State encodings, the timeout status code 32'h0000000A and the engine terminal codes 6–9 SHALL come from a shared include file common with painterengine_gpu_memcpy.
REQ-039 The round-robin selector SHALL be one sub-module, painterengine_gpu_rr_arbiter4, taking the request bits and last_grant and returning a one-hot grant.

Verification
REQ-040 Single job: req=4'b0001, src=32'h1000, dst=32'h2000, len=32'd512; engine model reaches 6 after 20 cycles -> engine ports show those values; done[0] pulses once; status=6; busy falls.
REQ-041 Fairness: req=4'b1111 held high -> grants occur in the order 0,1,2,3,0.
REQ-042 Engine error: engine model returns 8 -> error[k] pulses; status=32'h00000008; done stays 0.
REQ-043 Timeout: TIMEOUT_CYCLES=16, engine stuck at 3 -> error pulses 16 cycles after RUN; status=32'h0000000A; o_wire_memcpy_resetn falls.
REQ-044 Mid-job reset: assert i_wire_resetn=0 during WAIT -> all outputs are 0 asynchronously; after release, a new req=4'b0010 is granted normally.
REQ-045 Simultaneous events: engine state 6 arrives in the cycle the timeout expires -> done pulses, error does not.

Source files
------------

// File: rtl/painterengine_gpu_memcpy_arbiter_pkg.sv
// rtl/painterengine_gpu_memcpy_arbiter_pkg.sv - shared states and engine status codes
// Common with painterengine_gpu_memcpy so both sides agree on the state word.
package painterengine_gpu_memcpy_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_LOAD   = 3'd1,
    ARB_RUN    = 3'd2,
    ARB_WAIT   = 3'd3,
    ARB_REPORT = 3'd4
  } arb_state_e;

  localparam logic [31:0] MEMCPY_STATE_DONE   = 32'd6;
  localparam logic [31:0] MEMCPY_STATE_ERR_0  = 32'd7;
  localparam logic [31:0] MEMCPY_STATE_ERR_1  = 32'd8;
  localparam logic [31:0] MEMCPY_STATE_ERR_2  = 32'd9;
  localparam logic [31:0] ARB_STATUS_TIMEOUT  = 32'h0000000A;

  function automatic logic is_terminal(input logic [31:0] s);
    return (s >= MEMCPY_STATE_DONE) && (s <= MEMCPY_STATE_ERR_2);
  endfunction

  function automatic logic [1:0] onehot_to_index(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (oh[k]) idx = k[1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/painterengine_gpu_rr_arbiter4.sv
// rtl/painterengine_gpu_rr_arbiter4.sv - 4-way round-robin selector, one-hot result
// Search begins one past the last grant; the last grant itself has lowest priority.
module painterengine_gpu_rr_arbiter4 (
  input  logic [3:0] req_i,
  input  logic [1:0] last_grant_i,
  output logic [3:0] grant_o
);

  logic [1:0] idx;

  // Walk from lowest priority to highest so the nearest requester is assigned last.
  always_comb begin
    grant_o = 4'b0000;
    idx     = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      idx = last_grant_i + i[1:0];
      if (req_i[idx]) grant_o = 4'b0001 << idx;
    end
  end

endmodule

// File: rtl/painterengine_gpu_memcpy_arbiter.sv
// rtl/painterengine_gpu_memcpy_arbiter.sv - shares one memcpy engine among 4 requesters
// Latches the winner's job, runs the engine, and reports done/error back to the owner.
module painterengine_gpu_memcpy_arbiter
  import painterengine_gpu_memcpy_arbiter_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1048576
) (
  input  logic          i_wire_clock,
  input  logic          i_wire_resetn,
  input  logic [3:0]    i_wire_req,
  input  logic [127:0]  i_wire_source_address,
  input  logic [127:0]  i_wire_dest_address,
  input  logic [127:0]  i_wire_length,
  output logic [3:0]    o_wire_grant,
  output logic [3:0]    o_wire_done,
  output logic [3:0]    o_wire_error,
  output logic [31:0]   o_wire_status,
  output logic          o_wire_busy,
  output logic          o_wire_memcpy_resetn,
  output logic [31:0]   o_wire_memcpy_source_address,
  output logic [31:0]   o_wire_memcpy_dest_address,
  output logic [31:0]   o_wire_memcpy_length,
  input  logic [31:0]   i_wire_memcpy_state
);

  arb_state_e  state_q, state_d;
  logic [3:0]  grant_q, grant_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [31:0] len_q, len_d;
  logic [31:0] status_q, status_d;
  logic [31:0] count_q, count_d;

  logic [3:0]  rr_grant;
  logic [6:0]  owner_base;
  logic        engine_resetn;
  logic [3:0]  done_pulse;
  logic [3:0]  error_pulse;

  painterengine_gpu_rr_arbiter4 u_rr (
    .req_i        (i_wire_req),
    .last_grant_i (last_grant_q),
    .grant_o      (rr_grant)
  );

  assign owner_base = {onehot_to_index(grant_q), 5'd0};

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    src_d         = src_q;
    dst_d         = dst_q;
    len_d         = len_q;
    status_d      = status_q;
    count_d       = count_q;
    engine_resetn = 1'b0;
    done_pulse    = 4'b0000;
    error_pulse   = 4'b0000;
    case (state_q)
      ARB_IDLE: begin
        if (|i_wire_req) begin
          grant_d      = rr_grant;
          last_grant_d = onehot_to_index(rr_grant);
          state_d      = ARB_LOAD;
        end
      end
      ARB_LOAD: begin
        src_d   = i_wire_source_address[owner_base +: 32];
        dst_d   = i_wire_dest_address[owner_base +: 32];
        len_d   = i_wire_length[owner_base +: 32];
        state_d = ARB_RUN;
      end
      ARB_RUN: begin
        engine_resetn = 1'b1;
        count_d       = 32'd0;
        state_d       = ARB_WAIT;
      end
      ARB_WAIT: begin
        engine_resetn = 1'b1;
        if (count_q != 32'hFFFF_FFFF) count_d = count_q + 32'd1;
        // A terminal engine state wins over a timeout expiring in the same cycle.
        if (is_terminal(i_wire_memcpy_state)) begin
          status_d = i_wire_memcpy_state;
          state_d  = ARB_REPORT;
        end else if ((TIMEOUT_CYCLES != 32'd0) && (count_q >= TIMEOUT_CYCLES - 32'd1)) begin
          status_d = ARB_STATUS_TIMEOUT;
          state_d  = ARB_REPORT;
        end
      end
      ARB_REPORT: begin
        if (status_q == MEMCPY_STATE_DONE) done_pulse = grant_q;
        else error_pulse = grant_q;
        grant_d = 4'b0000;
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state_q      <= ARB_IDLE;
      grant_q      <= 4'b0000;
      last_grant_q <= 2'd3;
      src_q        <= 32'd0;
      dst_q        <= 32'd0;
      len_q        <= 32'd0;
      status_q     <= 32'd0;
      count_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      status_q     <= status_d;
      count_q      <= count_d;
    end
  end

  assign o_wire_grant                 = grant_q;
  assign o_wire_done                  = done_pulse;
  assign o_wire_error                 = error_pulse;
  assign o_wire_status                = status_q;
  assign o_wire_busy                  = (state_q != ARB_IDLE);
  assign o_wire_memcpy_resetn         = engine_resetn;
  assign o_wire_memcpy_source_address = src_q;
  assign o_wire_memcpy_dest_address   = dst_q;
  assign o_wire_memcpy_length         = len_q;

endmodule
